adder_tree_csa_acc: RTL
=======================

# adder_tree_csa_acc

Parametrised, fully pipelined carry-save adder tree that sums `I_DATA_N` operands of `I_DATA_W` bits per cycle. It adds valid tracking through the pipeline, a signed/unsigned build mode and a frame accumulator that totals `ACC_LEN` consecutive tree results. It sits between a parallel-sample producer, such as a filter tap bank or a multi-channel ADC front end, and downstream frame-rate logic. It replaces the fixed-size, always-valid tree with a width-exact, handshaked block.

## Interface
- `I_DATA_W`, 8: width of each input operand.
- `I_DATA_N`, 7: number of operands, ≥3.
- `SIGNED`, 0: 0 means operands are unsigned and zero-extended; 1 means two's complement and sign-extended.
- `ACC_LEN`, 4: number of tree results per accumulated frame, ≥1.
- `SUM_W` (localparam) = `I_DATA_W + $clog2(I_DATA_N)`.
- `O_DATA_W` (localparam) = `SUM_W + $clog2(ACC_LEN)`.
- `STAGES_N` (localparam) = number of 3:2 levels. Start with n=`I_DATA_N`; while n>2, set n = n − floor(n/3) and count one level. Values: N=3→1, 4→2, 7→4, 9→4.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; **asynchronous, active-high**.
- `i_data`  in  `[0:I_DATA_N-1][I_DATA_W-1:0]`  packed operand array; index 0 is the MSB slice.
- `i_valid`  in  1  qualifies `i_data` this cycle. No backpressure.
- `i_clear`  in  1  synchronous abort of the partial accumulation frame.
- `o_sum`  out  `SUM_W`  per-sample tree sum.
- `o_sum_valid`  out  1  one-cycle strobe per accepted sample.
- `o_acc`  out  `O_DATA_W`  frame total.
- `o_acc_valid`  out  1  one-cycle strobe per completed frame.

## Operation
- Operands are extended to `SUM_W` according to `SIGNED`.
- Each 3:2 level groups operands in triples of full adders and passes any leftover operands (remainder of n/3) through unchanged. Carry vectors are shifted left 1 and truncated to `SUM_W`. Every level is registered.
- The final carry-propagate add of the 2 remaining vectors is registered into `o_sum`.
- A valid bit travels alongside each stage. Data registers load only when the valid bit entering that stage is 1. Invalid slots are bubbles and never alter `o_sum` or `o_acc`.
- Widths are exact: no overflow is possible for any input combination, and there is no saturation logic.
- Accumulator has a counter `cnt` in 0..`ACC_LEN`−1 and a partial register `acc` of width `O_DATA_W`, extended per `SIGNED`.
- On `o_sum_valid` with `cnt`=0: `acc` ← `o_sum`.
- On `o_sum_valid` with `cnt`>0: `acc` ← `acc`+`o_sum`.
- When `cnt`=`ACC_LEN`−1, the new total goes to `o_acc`, `o_acc_valid` is set to 1 and `cnt` returns to 0. Otherwise `cnt` increments.
- `ACC_LEN`=1: every sum produces `o_acc` = extended `o_sum`.
- `i_clear` is sampled at the accumulator stage. It drops the partial frame and sets `cnt`=0 for that cycle's decision.
  - If `o_sum_valid` is also 1 in that cycle, the sample becomes element 0 of a new frame, or completes the frame if `ACC_LEN`=1.
  - `i_clear` does not flush samples still in flight in the tree.
- `o_sum` and `o_acc` hold their last valid value between strobes.

## Timing
- Reset values: all stage valid bits 0, `cnt`=0, `acc`=0, `o_sum`=0, `o_sum_valid`=0, `o_acc`=0, `o_acc_valid`=0.
- Latency: `i_valid` high at edge t gives `o_sum_valid` high after edge t+L, with L=`STAGES_N`+1. The default build has L=5.
- The frame total is produced one edge after the `o_sum_valid` of the frame's last sample.
- Throughput: 1 sample/cycle. Back-to-back frames produce `o_acc_valid` strobes every `ACC_LEN` cycles.
- Bubbles of any length are allowed. The frame count advances only on valid samples.
- Reset asserted mid-operation:
  - All in-flight samples and the partial frame are lost.
  - No strobe may appear after deassertion until new `i_valid` samples have propagated through the pipeline.

## Test plan
- **Single sample.** Default build, unsigned, all operands 255, one `i_valid` pulse at edge t.
  - `o_sum`=1785 with `o_sum_valid` high for exactly 1 cycle after edge t+5.
  - No `o_acc_valid`.
- **Back-to-back frame.** Four consecutive samples: all operands 1, then all 2, then all 3, then all 4.
  - `o_sum` sequence is 7, 14, 21, 28.
  - `o_acc`=70 with one `o_acc_valid` strobe one cycle after the 28.
- **Frame with bubbles.** Same four samples separated by gaps of 0, 3 and 1 idle cycles.
  - Identical sums and `o_acc`=70.
  - `cnt` must not advance on bubbles.
- **Clear.** Two samples of all 5, then `i_clear`, then four samples of all 1.
  - `o_acc`=28.
  - A clear coincident with the first of the four still yields 28.
- **Reset mid-frame.** Assert `rst` after 2 samples while 3 more are in flight.
  - Outputs read 0 and no strobes appear.
  - The next full frame of all-255 samples gives `o_acc`=7140.
- **Signed build.** `SIGNED`=1, all operands −128, 4 samples.
  - `o_sum`=−896 (11 bits).
  - `o_acc`=−3584 (13 bits).

Source files
------------

// File: rtl/adder_tree_csa_acc_if.sv
// Operand/result bundle for adder_tree_csa_acc.
// The producer drives the i_* signals (master); the tree drives the o_* signals (slave).
interface adder_tree_csa_acc_if #(
  parameter int I_DATA_W = 8,
  parameter int I_DATA_N = 7,
  parameter int ACC_LEN  = 4
);
  localparam int SUM_W    = I_DATA_W + $clog2(I_DATA_N);
  localparam int O_DATA_W = SUM_W + $clog2(ACC_LEN);

  logic [0:I_DATA_N-1][I_DATA_W-1:0] i_data;
  logic                              i_valid;
  logic                              i_clear;
  logic [SUM_W-1:0]                  o_sum;
  logic                              o_sum_valid;
  logic [O_DATA_W-1:0]               o_acc;
  logic                              o_acc_valid;

  modport master (
    output i_data, i_valid, i_clear,
    input  o_sum, o_sum_valid, o_acc, o_acc_valid
  );

  modport slave (
    input  i_data, i_valid, i_clear,
    output o_sum, o_sum_valid, o_acc, o_acc_valid
  );
endinterface

// File: rtl/adder_tree_csa_acc.sv
// Pipelined carry-save adder tree summing I_DATA_N operands per cycle, with valid
// tracking and a frame accumulator that totals ACC_LEN consecutive tree results.
module adder_tree_csa_acc #(
  parameter int I_DATA_W = 8,
  parameter int I_DATA_N = 7,
  parameter int SIGNED   = 0,
  parameter int ACC_LEN  = 4
) (
  input logic                clk,
  input logic                rst,
  adder_tree_csa_acc_if.slave bus
);
  localparam int SUM_W    = I_DATA_W + $clog2(I_DATA_N);
  localparam int O_DATA_W = SUM_W + $clog2(ACC_LEN);
  localparam int CNT_W    = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

  // Operand count entering level s of the 3:2 reduction.
  function automatic int lvl_cnt(input int s);
    int n;
    n = I_DATA_N;
    for (int unsigned k = 0; k < s; k++) n = n - n / 3;
    return n;
  endfunction

  function automatic int stages_calc();
    int n;
    int c;
    n = I_DATA_N;
    c = 0;
    while (n > 2) begin
      n = n - n / 3;
      c++;
    end
    return c;
  endfunction

  localparam int STAGES_N = stages_calc();

  logic [I_DATA_N*SUM_W-1:0] ext;

  always_comb begin
    ext = '0;
    for (int unsigned k = 0; k < I_DATA_N; k++)
      ext[k*SUM_W +: SUM_W] = {{(SUM_W-I_DATA_W){(SIGNED != 0) && bus.i_data[k][I_DATA_W-1]}},
                               bus.i_data[k]};
  end

  for (genvar s = 0; s < STAGES_N; s++) begin : g_lvl
    localparam int NI = lvl_cnt(s);
    localparam int NO = lvl_cnt(s + 1);
    localparam int T  = NI / 3;
    localparam int R  = NI % 3;

    logic [NI*SUM_W-1:0] din;
    logic                vin;
    logic [NO*SUM_W-1:0] dnx;
    logic [NO*SUM_W-1:0] q;
    logic                vq;

    if (s == 0) begin : g_src
      assign din = ext;
      assign vin = bus.i_valid;
    end else begin : g_src
      assign din = g_lvl[s-1].q;
      assign vin = g_lvl[s-1].vq;
    end

    // Triple t yields sum at slot 2t and carry at 2t+1; leftovers follow unchanged.
    always_comb begin
      logic [SUM_W-1:0] a, b, c;
      a   = '0;
      b   = '0;
      c   = '0;
      dnx = '0;
      for (int unsigned t = 0; t < T; t++) begin
        a = din[(3*t)*SUM_W +: SUM_W];
        b = din[(3*t+1)*SUM_W +: SUM_W];
        c = din[(3*t+2)*SUM_W +: SUM_W];
        dnx[(2*t)*SUM_W +: SUM_W]   = a ^ b ^ c;
        dnx[(2*t+1)*SUM_W +: SUM_W] = ((a & b) | (a & c) | (b & c)) << 1;
      end
      for (int unsigned r = 0; r < R; r++)
        dnx[(2*T+r)*SUM_W +: SUM_W] = din[(3*T+r)*SUM_W +: SUM_W];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q  <= '0;
        vq <= 1'b0;
      end else begin
        vq <= vin;
        if (vin) q <= dnx;
      end
    end
  end

  logic [2*SUM_W-1:0] last_q;
  logic               last_v;

  assign last_q = g_lvl[STAGES_N-1].q;
  assign last_v = g_lvl[STAGES_N-1].vq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.o_sum       <= '0;
      bus.o_sum_valid <= 1'b0;
    end else begin
      bus.o_sum_valid <= last_v;
      if (last_v) bus.o_sum <= last_q[SUM_W +: SUM_W] + last_q[0 +: SUM_W];
    end
  end

  logic [O_DATA_W-1:0] sum_ext;

  if (O_DATA_W > SUM_W) begin : g_sx
    assign sum_ext = {{(O_DATA_W-SUM_W){(SIGNED != 0) && bus.o_sum[SUM_W-1]}}, bus.o_sum};
  end else begin : g_sx
    assign sum_ext = bus.o_sum;
  end

  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_eff;
  logic [O_DATA_W-1:0] acc;
  logic [O_DATA_W-1:0] acc_nx;

  // A clear restarts the frame in the same cycle, so a coincident sample becomes element 0.
  always_comb begin
    cnt_eff = bus.i_clear ? '0 : cnt;
    acc_nx  = (cnt_eff == '0) ? sum_ext : acc + sum_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt             <= '0;
      acc             <= '0;
      bus.o_acc       <= '0;
      bus.o_acc_valid <= 1'b0;
    end else begin
      bus.o_acc_valid <= 1'b0;
      if (bus.o_sum_valid) begin
        acc <= acc_nx;
        if (cnt_eff == CNT_W'(ACC_LEN - 1)) begin
          cnt             <= '0;
          bus.o_acc       <= acc_nx;
          bus.o_acc_valid <= 1'b1;
        end else begin
          cnt <= cnt_eff + CNT_W'(1);
        end
      end else if (bus.i_clear) begin
        cnt <= '0;
      end
    end
  end
endmodule
